// File: rtl/regfile_write_scheduler.sv
// Register-file write-port arbiter with a per-register pending scoreboard.
// Stalls decode on RAW/WAW hazards and drives a registered write port.
module regfile_write_scheduler #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter int ARB_MODE = 0
) (
  input  logic              clk,
  input  logic              resetIn,
  input  logic              issueValid,
  input  logic              issueWritesRd,
  input  logic [ADDR_W-1:0] issueRd,
  input  logic [ADDR_W-1:0] issueRs1,
  input  logic [ADDR_W-1:0] issueRs2,
  output logic              stallOut,
  input  logic              wbValidA,
  input  logic [ADDR_W-1:0] wbAddrA,
  input  logic [DATA_W-1:0] wbDataA,
  output logic              wbReadyA,
  input  logic              wbValidB,
  input  logic [ADDR_W-1:0] wbAddrB,
  input  logic [DATA_W-1:0] wbDataB,
  output logic              wbReadyB,
  output logic              writeEnable,
  output logic [ADDR_W-1:0] writeAddr,
  output logic [DATA_W-1:0] writeDate,
  output logic [ADDR_W:0]   pendingCount,
  output logic              errorOut
);

  typedef enum logic {
    GNT_A = 1'b0,
    GNT_B = 1'b1
  } gnt_e;

  localparam int SPAN = 2 ** ADDR_W;

  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                err_q, err_d;
  gnt_e                last_q, last_d;

  logic [SPAN-1:0]     pend_ext;
  logic                gnt_a, gnt_b;
  logic                xfer;
  logic [ADDR_W-1:0]   xaddr;
  logic [DATA_W-1:0]   xdata;
  logic                retire;
  logic                was_pend;
  logic                issue;
  logic                hazard;

  // Addresses beyond NUM_REGS read as never pending.
  always_comb begin
    pend_ext = '0;
    pend_ext[NUM_REGS-1:0] = pend_q;
  end

  always_comb begin
    hazard = pend_ext[issueRs1] | pend_ext[issueRs2]
           | (issueWritesRd & pend_ext[issueRd]);
    stallOut = ~resetIn & issueValid & hazard;
  end

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (!resetIn) begin
      if (wbValidA && (!wbValidB || ARB_MODE == 1 || last_q == GNT_B))
        gnt_a = 1'b1;
      else if (wbValidB)
        gnt_b = 1'b1;
    end
  end

  assign wbReadyA = gnt_a;
  assign wbReadyB = gnt_b;

  always_comb begin
    xfer     = gnt_a | gnt_b;
    xaddr    = gnt_a ? wbAddrA : wbAddrB;
    xdata    = gnt_a ? wbDataA : wbDataB;
    retire   = xfer & (xaddr != '0);
    was_pend = pend_ext[xaddr];
    issue    = ~resetIn & issueValid & ~stallOut
             & issueWritesRd & (issueRd != '0);
  end

  always_comb begin
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    we_d    = retire;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    last_d  = last_q;
    if (xfer) begin
      waddr_d = xaddr;
      wdata_d = xdata;
      last_d  = gnt_b ? GNT_B : GNT_A;
    end
    if (retire) begin
      if (int'(xaddr) < NUM_REGS)
        pend_d[xaddr] = 1'b0;
      if (!was_pend)
        err_d = 1'b1;
    end
    if (issue && int'(issueRd) < NUM_REGS)
      pend_d[issueRd] = 1'b1;
    // Count tracks real bit transitions so an erroneous retire cannot underflow it.
    if (issue && !(retire && was_pend))
      cnt_d = cnt_q + (ADDR_W+1)'(1);
    else if (!issue && retire && was_pend)
      cnt_d = cnt_q - (ADDR_W+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (resetIn) begin
      pend_q  <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      last_q  <= GNT_B;
    end else begin
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      last_q  <= last_d;
    end
  end

  assign writeEnable  = we_q;
  assign writeAddr    = waddr_q;
  assign writeDate    = wdata_q;
  assign pendingCount = cnt_q;
  assign errorOut     = err_q;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Bench for regfile_write_scheduler: directed scenarios plus a random run
// against a scoreboard model; dut1 runs fixed-priority arbitration.
module tb_regfile_write_scheduler;

  logic        clk = 1'b0;
  logic        resetIn;
  logic        issueValid, issueWritesRd;
  logic [4:0]  issueRd, issueRs1, issueRs2;
  logic        wbValidA, wbValidB;
  logic [4:0]  wbAddrA, wbAddrB;
  logic [31:0] wbDataA, wbDataB;

  logic        stall0, rdyA0, rdyB0, we0, err0;
  logic [4:0]  wa0;
  logic [31:0] wd0;
  logic [5:0]  cnt0;
  logic        stall1, rdyA1, rdyB1, we1, err1;
  logic [4:0]  wa1;
  logic [31:0] wd1;
  logic [5:0]  cnt1;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  regfile_write_scheduler #(.ARB_MODE(0)) dut0 (
    .clk(clk), .resetIn(resetIn),
    .issueValid(issueValid), .issueWritesRd(issueWritesRd),
    .issueRd(issueRd), .issueRs1(issueRs1), .issueRs2(issueRs2),
    .stallOut(stall0),
    .wbValidA(wbValidA), .wbAddrA(wbAddrA), .wbDataA(wbDataA),
    .wbReadyA(rdyA0),
    .wbValidB(wbValidB), .wbAddrB(wbAddrB), .wbDataB(wbDataB),
    .wbReadyB(rdyB0),
    .writeEnable(we0), .writeAddr(wa0), .writeDate(wd0),
    .pendingCount(cnt0), .errorOut(err0)
  );

  regfile_write_scheduler #(.ARB_MODE(1)) dut1 (
    .clk(clk), .resetIn(resetIn),
    .issueValid(issueValid), .issueWritesRd(issueWritesRd),
    .issueRd(issueRd), .issueRs1(issueRs1), .issueRs2(issueRs2),
    .stallOut(stall1),
    .wbValidA(wbValidA), .wbAddrA(wbAddrA), .wbDataA(wbDataA),
    .wbReadyA(rdyA1),
    .wbValidB(wbValidB), .wbAddrB(wbAddrB), .wbDataB(wbDataB),
    .wbReadyB(rdyB1),
    .writeEnable(we1), .writeAddr(wa1), .writeDate(wd1),
    .pendingCount(cnt1), .errorOut(err1)
  );

  task automatic idle_inputs;
    issueValid = 0; issueWritesRd = 0;
    issueRd = 0; issueRs1 = 0; issueRs2 = 0;
    wbValidA = 0; wbAddrA = 0; wbDataA = 0;
    wbValidB = 0; wbAddrB = 0; wbDataB = 0;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    idle_inputs();
    resetIn = 1;
    tick();
    tick();
    resetIn = 0;
  endtask

  task automatic test_reset;
    idle_inputs();
    resetIn = 1;
    wbValidA = 1; wbAddrA = 5'd4;
    wbValidB = 1; wbAddrB = 5'd6;
    issueValid = 1; issueWritesRd = 1; issueRd = 5'd2;
    tick();
    #2;
    n_chk++; if (rdyA0 !== 1'b0) begin n_fail++; $display("FAIL rst_rdyA got %0b exp 0", rdyA0); end
    n_chk++; if (rdyB0 !== 1'b0) begin n_fail++; $display("FAIL rst_rdyB got %0b exp 0", rdyB0); end
    n_chk++; if (stall0 !== 1'b0) begin n_fail++; $display("FAIL rst_stall got %0b exp 0", stall0); end
    tick();
    idle_inputs();
    resetIn = 0;
    repeat (5) tick();
    n_chk++; if (we0 !== 1'b0) begin n_fail++; $display("FAIL idle_we got %0b exp 0", we0); end
    n_chk++; if (wa0 !== 5'd0) begin n_fail++; $display("FAIL idle_wa got %0h exp 0", wa0); end
    n_chk++; if (wd0 !== 32'd0) begin n_fail++; $display("FAIL idle_wd got %0h exp 0", wd0); end
    n_chk++; if (cnt0 !== 6'd0) begin n_fail++; $display("FAIL idle_cnt got %0d exp 0", cnt0); end
    n_chk++; if (err0 !== 1'b0) begin n_fail++; $display("FAIL idle_err got %0b exp 0", err0); end
    n_chk++; if (stall0 !== 1'b0) begin n_fail++; $display("FAIL idle_stall got %0b exp 0", stall0); end
  endtask

  task automatic test_raw;
    do_reset();
    issueValid = 1; issueWritesRd = 1; issueRd = 5'd5;
    #2;
    n_chk++; if (stall0 !== 1'b0) begin n_fail++; $display("FAIL raw_issue_stall got %0b exp 0", stall0); end
    tick();
    n_chk++; if (cnt0 !== 6'd1) begin n_fail++; $display("FAIL raw_cnt1 got %0d exp 1", cnt0); end
    issueWritesRd = 0; issueRd = 5'd1; issueRs1 = 5'd5;
    wbValidA = 1; wbAddrA = 5'd5; wbDataA = 32'hDEADBEEF;
    #2;
    n_chk++; if (stall0 !== 1'b1) begin n_fail++; $display("FAIL raw_stall got %0b exp 1", stall0); end
    n_chk++; if (rdyA0 !== 1'b1) begin n_fail++; $display("FAIL raw_rdyA got %0b exp 1", rdyA0); end
    tick();
    wbValidA = 0;
    n_chk++; if (we0 !== 1'b1) begin n_fail++; $display("FAIL raw_we got %0b exp 1", we0); end
    n_chk++; if (wa0 !== 5'd5) begin n_fail++; $display("FAIL raw_wa got %0h exp 5", wa0); end
    n_chk++; if (wd0 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL raw_wd got %0h exp deadbeef", wd0); end
    n_chk++; if (cnt0 !== 6'd0) begin n_fail++; $display("FAIL raw_cnt0 got %0d exp 0", cnt0); end
    #2;
    n_chk++; if (stall0 !== 1'b0) begin n_fail++; $display("FAIL raw_unstall got %0b exp 0", stall0); end
    tick();
    n_chk++; if (we0 !== 1'b0) begin n_fail++; $display("FAIL raw_we_drop got %0b exp 0", we0); end
    n_chk++; if (wd0 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL raw_wd_hold got %0h exp deadbeef", wd0); end
    idle_inputs();
  endtask

  task automatic test_arb_rr;
    do_reset();
    issueValid = 1; issueWritesRd = 1; issueRd = 5'd3;
    tick();
    issueRd = 5'd7;
    tick();
    idle_inputs();
    n_chk++; if (cnt0 !== 6'd2) begin n_fail++; $display("FAIL rr_cnt2 got %0d exp 2", cnt0); end
    wbValidA = 1; wbAddrA = 5'd3; wbDataA = 32'h33;
    wbValidB = 1; wbAddrB = 5'd7; wbDataB = 32'h77;
    #2;
    n_chk++; if (rdyA0 !== 1'b1) begin n_fail++; $display("FAIL rr_first_rdyA got %0b exp 1", rdyA0); end
    n_chk++; if (rdyB0 !== 1'b0) begin n_fail++; $display("FAIL rr_first_rdyB got %0b exp 0", rdyB0); end
    tick();
    wbValidA = 0;
    n_chk++; if (wa0 !== 5'd3 || we0 !== 1'b1) begin n_fail++; $display("FAIL rr_write3 got we=%0b addr=%0h exp we=1 addr=3", we0, wa0); end
    n_chk++; if (cnt0 !== 6'd1) begin n_fail++; $display("FAIL rr_cnt1 got %0d exp 1", cnt0); end
    #2;
    n_chk++; if (rdyB0 !== 1'b1) begin n_fail++; $display("FAIL rr_second_rdyB got %0b exp 1", rdyB0); end
    tick();
    wbValidB = 0;
    n_chk++; if (wa0 !== 5'd7 || wd0 !== 32'h77) begin n_fail++; $display("FAIL rr_write7 got addr=%0h data=%0h exp addr=7 data=77", wa0, wd0); end
    n_chk++; if (cnt0 !== 6'd0) begin n_fail++; $display("FAIL rr_cnt0 got %0d exp 0", cnt0); end
    n_chk++; if (err0 !== 1'b0) begin n_fail++; $display("FAIL rr_err got %0b exp 0", err0); end
  endtask

  task automatic test_arb_fixed;
    logic [31:0] d;
    do_reset();
    wbValidB = 1; wbAddrB = 5'd7; wbDataB = 32'h7777;
    for (int i = 0; i < 4; i++) begin
      d = $urandom;
      wbValidA = 1; wbAddrA = 5'd0; wbDataA = d;
      #2;
      n_chk++; if (rdyA1 !== 1'b1) begin n_fail++; $display("FAIL fix_rdyA[%0d] got %0b exp 1", i, rdyA1); end
      n_chk++; if (rdyB1 !== 1'b0) begin n_fail++; $display("FAIL fix_rdyB[%0d] got %0b exp 0", i, rdyB1); end
      tick();
      n_chk++; if (wd1 !== d) begin n_fail++; $display("FAIL fix_wd[%0d] got %0h exp %0h", i, wd1, d); end
    end
    idle_inputs();
  endtask

  task automatic test_x0_error;
    do_reset();
    wbValidA = 1; wbAddrA = 5'd0; wbDataA = 32'h1;
    #2;
    n_chk++; if (rdyA0 !== 1'b1) begin n_fail++; $display("FAIL x0_rdy got %0b exp 1", rdyA0); end
    tick();
    n_chk++; if (we0 !== 1'b0) begin n_fail++; $display("FAIL x0_we got %0b exp 0", we0); end
    n_chk++; if (err0 !== 1'b0) begin n_fail++; $display("FAIL x0_err got %0b exp 0", err0); end
    wbAddrA = 5'd9; wbDataA = 32'h99;
    tick();
    wbValidA = 0;
    n_chk++; if (we0 !== 1'b1 || wa0 !== 5'd9) begin n_fail++; $display("FAIL err_write got we=%0b addr=%0h exp we=1 addr=9", we0, wa0); end
    n_chk++; if (err0 !== 1'b1) begin n_fail++; $display("FAIL err_set got %0b exp 1", err0); end
    n_chk++; if (cnt0 !== 6'd0) begin n_fail++; $display("FAIL err_cnt got %0d exp 0", cnt0); end
    repeat (3) tick();
    n_chk++; if (err0 !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %0b exp 1", err0); end
  endtask

  task automatic test_mid_reset;
    do_reset();
    issueValid = 1; issueWritesRd = 1; issueRd = 5'd12;
    tick();
    n_chk++; if (cnt0 !== 6'd1) begin n_fail++; $display("FAIL mr_cnt1 got %0d exp 1", cnt0); end
    issueWritesRd = 0; issueRs1 = 5'd12;
    wbValidB = 1; wbAddrB = 5'd12; wbDataB = 32'hC;
    resetIn = 1;
    #2;
    n_chk++; if (rdyB0 !== 1'b0) begin n_fail++; $display("FAIL mr_rdyB got %0b exp 0", rdyB0); end
    n_chk++; if (stall0 !== 1'b0) begin n_fail++; $display("FAIL mr_stall_rst got %0b exp 0", stall0); end
    tick();
    resetIn = 0;
    wbValidB = 0;
    #2;
    n_chk++; if (stall0 !== 1'b0) begin n_fail++; $display("FAIL mr_stall_after got %0b exp 0", stall0); end
    n_chk++; if (cnt0 !== 6'd0) begin n_fail++; $display("FAIL mr_cnt0 got %0d exp 0", cnt0); end
    n_chk++; if (we0 !== 1'b0) begin n_fail++; $display("FAIL mr_we got %0b exp 0", we0); end
    tick();
    idle_inputs();
  endtask

  task automatic test_random;
    bit          pm[32];
    bit          last_b, m_err, m_we, e_stall, ga, gb;
    logic [4:0]  m_wa, xa;
    logic [31:0] m_wd, xd;
    int          pend_list[$];
    int          m_cnt;
    do_reset();
    foreach (pm[i]) pm[i] = 0;
    last_b = 1; m_err = 0; m_we = 0; m_wa = 0; m_wd = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      pend_list.delete();
      for (int r = 1; r < 32; r++) if (pm[r]) pend_list.push_back(r);
      if (!wbValidA && ($urandom % 3 == 0)) begin
        if ($urandom % 10 == 0) wbAddrA = 5'($urandom);
        else if (pend_list.size() > 0) wbAddrA = 5'(pend_list[$urandom % pend_list.size()]);
        else wbAddrA = 5'd0;
        wbValidA = 1; wbDataA = $urandom;
      end
      if (!wbValidB && ($urandom % 3 == 0)) begin
        if ($urandom % 10 == 0) wbAddrB = 5'($urandom);
        else if (pend_list.size() > 0) wbAddrB = 5'(pend_list[$urandom % pend_list.size()]);
        else wbAddrB = 5'd0;
        wbValidB = 1; wbDataB = $urandom;
      end
      issueValid = 1'($urandom); issueWritesRd = 1'($urandom);
      issueRd = 5'($urandom); issueRs1 = 5'($urandom); issueRs2 = 5'($urandom);
      e_stall = issueValid && (pm[issueRs1] || pm[issueRs2] || (issueWritesRd && pm[issueRd]));
      ga = wbValidA && (!wbValidB || last_b);
      gb = wbValidB && !ga;
      #2;
      n_chk++; if (stall0 !== e_stall || rdyA0 !== ga || rdyB0 !== gb) begin
        n_fail++;
        $display("FAIL rnd_comb[%0d] got stall=%0b rA=%0b rB=%0b exp stall=%0b rA=%0b rB=%0b",
                 cyc, stall0, rdyA0, rdyB0, e_stall, ga, gb);
      end
      m_we = 0;
      if (ga || gb) begin
        xa = ga ? wbAddrA : wbAddrB;
        xd = ga ? wbDataA : wbDataB;
        m_wa = xa; m_wd = xd; last_b = gb;
        if (xa != 0) begin
          m_we = 1;
          if (!pm[xa]) m_err = 1;
          pm[xa] = 0;
        end
      end
      if (issueValid && !e_stall && issueWritesRd && issueRd != 0) pm[issueRd] = 1;
      m_cnt = 0;
      foreach (pm[i]) m_cnt += int'(pm[i]);
      tick();
      if (ga) wbValidA = 0;
      if (gb) wbValidB = 0;
      n_chk++; if (we0 !== m_we || wa0 !== m_wa || wd0 !== m_wd) begin
        n_fail++;
        $display("FAIL rnd_wr[%0d] got we=%0b a=%0h d=%0h exp we=%0b a=%0h d=%0h",
                 cyc, we0, wa0, wd0, m_we, m_wa, m_wd);
      end
      n_chk++; if (int'(cnt0) !== m_cnt || err0 !== m_err) begin
        n_fail++;
        $display("FAIL rnd_cnt[%0d] got cnt=%0d err=%0b exp cnt=%0d err=%0b",
                 cyc, cnt0, err0, m_cnt, m_err);
      end
    end
    idle_inputs();
  endtask

  initial begin
    resetIn = 1;
    idle_inputs();
    #1;
    test_reset();
    test_raw();
    test_arb_rr();
    test_arb_fixed();
    test_x0_error();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
